// File: rtl/mm_sequencer.sv
// -----------------------------------------------------------------------------
// mm_sequencer
//
// Central phase sequencer for the matrix-multiply datapath. It walks the
// datapath through four phases:
//   1. input loading          (input_load_en high until the loader reports done)
//   2. per-element compute    (alu_en high until the ALU pulses alu_done)
//   3. result write-back      (one-cycle active-low web strobe at ram_addr)
//   4. host readout           (ry high, ram_addr advances on each read_n low)
// Phases 2 and 3 repeat N_OUT times before readout starts. A one-cycle
// finish pulse closes the run and the sequencer returns to idle.
//
// Every output is a register loaded from a decode of the *next* state. The
// outputs therefore line up with the state they describe, one clock after
// the input that caused the transition, and they are glitch-free.
//
// Parameters
//   N_OUT   number of result elements per run (>= 2)
//   ADDR_W  result-SRAM address width, 2**ADDR_W >= N_OUT
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous reset, active low
//   start_in       in   run request, honoured only when idle
//   xload_done     in   input loader finished, honoured only while loading
//   alu_done       in   current result valid, honoured only while computing
//   read_n         in   host read request (active low), honoured only in readout
//   input_load_en  out  enables X input loading
//   alu_en         out  enables the ALU for the current element
//   web            out  result-SRAM write enable, active low
//   ram_addr       out  result-SRAM address (write address, then read address)
//   ry             out  results available for readout
//   finish         out  one-cycle pulse when readout completes
//   busy           out  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module mm_sequencer #(
  parameter int N_OUT  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              xload_done,
  input  logic              alu_done,
  input  logic              read_n,
  output logic              input_load_en,
  output logic              alu_en,
  output logic              web,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ry,
  output logic              finish,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_WRITE   = 3'd3,
    S_READOUT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Terminal element index; the counter is compared against this before it
  // is incremented so it never wraps.
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(N_OUT - 1);
  localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic              input_load_en_q, input_load_en_d;
  logic              alu_en_q, alu_en_d;
  logic              web_q, web_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ry_q, ry_d;
  logic              finish_q, finish_d;
  logic              busy_q, busy_d;

  // ---------------------------------------------------------------------------
  // State, counter and output registers. Reset forces idle immediately, which
  // also deasserts web so no write can be issued once reset is seen.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      input_load_en_q <= 1'b0;
      alu_en_q        <= 1'b0;
      web_q           <= 1'b1;
      ram_addr_q      <= '0;
      ry_q            <= 1'b0;
      finish_q        <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      input_load_en_q <= input_load_en_d;
      alu_en_q        <= alu_en_d;
      web_q           <= web_d;
      ram_addr_q      <= ram_addr_d;
      ry_q            <= ry_d;
      finish_q        <= finish_d;
      busy_q          <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and element counter. Each state looks only at its own input;
  // anything else arriving in that state is ignored. In COMPUTE only alu_done
  // is examined, so a coincident xload_done has no effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end

      S_LOAD: begin
        if (xload_done) begin
          state_d = S_COMPUTE;
        end
      end

      S_COMPUTE: begin
        if (alu_done) begin
          state_d = S_WRITE;
        end
      end

      // Write-back always lasts a single cycle.
      S_WRITE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_READOUT;
          cnt_d   = '0;
        end else begin
          state_d = S_COMPUTE;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      // The host may pause for any number of cycles by holding read_n high.
      S_READOUT: begin
        if (!read_n) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, so the registered outputs describe the
  // state the sequencer is entering. ram_addr follows the counter only while
  // it is meaningful (write-back and readout) and rests at zero otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    input_load_en_d = 1'b0;
    alu_en_d        = 1'b0;
    web_d           = 1'b1;
    ram_addr_d      = '0;
    ry_d            = 1'b0;
    finish_d        = 1'b0;
    busy_d          = (state_d != S_IDLE);

    unique case (state_d)
      S_LOAD:    input_load_en_d = 1'b1;
      S_COMPUTE: alu_en_d        = 1'b1;
      S_WRITE: begin
        web_d      = 1'b0;
        ram_addr_d = cnt_d;
      end
      S_READOUT: begin
        ry_d       = 1'b1;
        ram_addr_d = cnt_d;
      end
      S_DONE:    finish_d        = 1'b1;
      default: begin
        input_load_en_d = 1'b0;
      end
    endcase
  end

  assign input_load_en = input_load_en_q;
  assign alu_en        = alu_en_q;
  assign web           = web_q;
  assign ram_addr      = ram_addr_q;
  assign ry            = ry_q;
  assign finish        = finish_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mm_sequencer.sv
module tb_mm_sequencer;

  localparam int N_OUT  = 4;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start_in = 1'b0;
  logic              xload_done = 1'b0;
  logic              alu_done = 1'b0;
  logic              read_n = 1'b1;
  logic              input_load_en;
  logic              alu_en;
  logic              web;
  logic [ADDR_W-1:0] ram_addr;
  logic              ry;
  logic              finish;
  logic              busy;

  mm_sequencer #(.N_OUT(N_OUT), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_in     (start_in),
    .xload_done   (xload_done),
    .alu_done     (alu_done),
    .read_n       (read_n),
    .input_load_en(input_load_en),
    .alu_en       (alu_en),
    .web          (web),
    .ram_addr     (ram_addr),
    .ry           (ry),
    .finish       (finish),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Output vector layout: {input_load_en, alu_en, web, ram_addr[2:0], ry, finish, busy}
  logic [8:0] outs;
  assign outs = {input_load_en, alu_en, web, ram_addr, ry, finish, busy};

  localparam logic [8:0] O_IDLE = {3'b001, 3'd0, 3'b000};
  localparam logic [8:0] O_LOAD = {3'b101, 3'd0, 3'b001};
  localparam logic [8:0] O_COMP = {3'b011, 3'd0, 3'b001};
  localparam logic [8:0] O_DONE = {3'b001, 3'd0, 3'b011};

  function automatic logic [8:0] o_wr(input logic [2:0] a);
    return {3'b000, a, 3'b001};
  endfunction

  function automatic logic [8:0] o_rd(input logic [2:0] a);
    return {3'b001, a, 3'b101};
  endfunction

  typedef struct {
    logic       s;
    logic       x;
    logic       a;
    logic       r;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic s, input logic x, input logic a, input logic r,
                     input logic [8:0] exp);
    vec_t v;
    v.s = s; v.x = x; v.a = a; v.r = r; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [8:0] exp);
    total++;
    if (outs !== exp) begin
      bad++;
      $display("FAIL %s got=%b expected=%b (ile,ae,web,addr,ry,fin,busy)", nm, outs, exp);
    end
  endtask

  task automatic step(input logic s, input logic x, input logic a, input logic r);
    start_in   = s;
    xload_done = x;
    alu_done   = a;
    read_n     = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Full run with spurious inputs sprinkled in; ends with start_in high
    // during DONE, which must be ignored.
    add(1, 0, 0, 1, O_LOAD);
    add(0, 0, 1, 1, O_LOAD);   // alu_done in LOAD
    add(0, 0, 0, 0, O_LOAD);   // read_n low in LOAD
    add(1, 0, 0, 1, O_LOAD);   // start_in in LOAD
    add(0, 0, 0, 1, O_LOAD);
    add(0, 1, 0, 1, O_COMP);
    for (int e = 0; e < N_OUT; e++) begin
      add(0, 1, 0, 0, O_COMP);           // xload_done and read_n low in COMPUTE
      add(0, 0, 1, 1, o_wr(3'(e)));
      if (e < N_OUT - 1) add(1, 0, 1, 1, O_COMP);  // start/alu_done during WRITE
      else               add(1, 0, 1, 1, o_rd(3'd0));
    end
    add(0, 0, 0, 0, o_rd(3'd1));
    add(0, 0, 0, 0, o_rd(3'd2));
    add(0, 0, 0, 0, o_rd(3'd3));
    add(0, 0, 0, 0, O_DONE);
    add(1, 0, 0, 1, O_IDLE);   // start_in during DONE ignored

    // Reset held with start_in high
    rst = 1'b0;
    start_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", O_IDLE);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      check("idle_after_reset", O_IDLE);
    end

    // Two back-to-back runs: second start lands in the cycle after DONE
    for (int run = 0; run < 2; run++) begin
      foreach (tbl[i]) begin
        step(tbl[i].s, tbl[i].x, tbl[i].a, tbl[i].r);
        check($sformatf("run%0d_vec%0d", run, i), tbl[i].exp);
      end
    end
    step(0, 0, 0, 1);
    check("idle_after_runs", O_IDLE);

    // Readout pause
    step(1, 0, 0, 1); check("pause_load", O_LOAD);
    step(0, 1, 0, 1); check("pause_comp", O_COMP);
    for (int e = 0; e < N_OUT; e++) begin
      step(0, 0, 1, 1); check("pause_wr", o_wr(3'(e)));
      step(0, 0, 0, 1);
      if (e < N_OUT - 1) check("pause_comp_n", O_COMP);
      else               check("pause_ry", o_rd(3'd0));
    end
    step(0, 0, 0, 0); check("pause_rd_a", o_rd(3'd1));
    step(0, 0, 0, 1); check("pause_hold_a", o_rd(3'd1));
    step(0, 0, 0, 1); check("pause_hold_b", o_rd(3'd1));
    step(0, 0, 0, 0); check("pause_rd_b", o_rd(3'd2));
    step(0, 0, 0, 0); check("pause_rd_c", o_rd(3'd3));
    step(0, 0, 0, 0); check("pause_finish", O_DONE);
    step(0, 0, 0, 1); check("pause_fin_once", O_IDLE);

    // Reset asserted asynchronously while writing element 2
    step(1, 0, 0, 1); check("mid_load", O_LOAD);
    step(0, 1, 0, 1); check("mid_comp", O_COMP);
    for (int e = 0; e < 2; e++) begin
      step(0, 0, 1, 1); check("mid_wr", o_wr(3'(e)));
      step(0, 0, 0, 1); check("mid_comp_n", O_COMP);
    end
    step(0, 0, 1, 1); check("mid_wr2", o_wr(3'd2));
    #2 rst = 1'b0;
    #1 check("async_reset", O_IDLE);
    @(posedge clk);
    #1 check("reset_held", O_IDLE);
    rst = 1'b1;
    step(0, 0, 1, 1); check("no_act_after_reset", O_IDLE);
    step(1, 0, 0, 1); check("restart_load", O_LOAD);
    step(0, 1, 0, 1); check("restart_comp", O_COMP);
    step(0, 0, 1, 1); check("restart_cnt0", o_wr(3'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
